md_sequencer: RTL and testbench
===============================

Name: md_sequencer

Overview:
- Multi-cycle multiply/divide controller for the execute stage; owns the HI/LO registers.
- Accepts mult/multu/div/divu/mthi/mtlo ops from the decoded instruction stream.
- Models MULT_LAT/DIV_LAT-cycle occupancy and commits results to HI/LO at the end.
- Drives the pipeline stall for any mult/div-family or mfhi/mflo instruction that arrives while the unit is busy.

Parameters:
MULT_LAT, 5, cycles busy for mult/multu (legal range 1..15)
DIV_LAT, 10, cycles busy for div/divu (legal range 1..15)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous, active-low reset
start_in  input  1  E-stage holds a valid mult/div-family instruction this cycle
op_in  input  3  MD op code (package constants)
rs_in  input  32  operand A (dividend / multiplicand / mthi-mtlo source)
rt_in  input  32  operand B (divisor / multiplier)
mf_req_in  input  1  E-stage holds mfhi or mflo
busy_out  input-independent output  1  unit occupied (registered)
stall_out  output  1  combinational stall request to the pipeline
done_out  output  1  one-cycle pulse in the cycle HI/LO commit becomes visible
hi_out  output  32  HI register
lo_out  output  32  LO register

Behaviour:
- Op codes: MD_NONE=0, MD_MULT=1, MD_MULTU=2, MD_DIV=3, MD_DIVU=4, MD_MTHI=5, MD_MTLO=6; 7 is reserved and treated as MD_NONE.
- Reset (async, rst_n low):
  - FSM=IDLE, counter=0.
  - hi_out=0, lo_out=0, busy_out=0, done_out=0.
  - Any in-flight op is discarded.
- FSM states: IDLE, BUSY_MUL, BUSY_DIV.
- stall_out = busy_out & (mf_req_in | (start_in & op_in != MD_NONE)). It is purely combinational; it is 0 in IDLE.
- Accept condition: start_in & (state==IDLE). Ops presented while stall_out=1 are ignored, and upstream holds them.
- Accept of MULT/MULTU:
  - The 64-bit product (signed or unsigned) is captured into a pending register at the edge.
  - state<=BUSY_MUL, counter<=MULT_LAT-1, busy_out<=1.
- Accept of DIV/DIVU:
  - Quotient and remainder are captured into the pending register.
  - state<=BUSY_DIV, counter<=DIV_LAT-1, busy_out<=1.
- Accept of MTHI/MTLO:
  - hi_out (or lo_out) <= rs_in at the edge.
  - No busy, no done pulse, stays IDLE.
- Busy states:
  - The counter decrements each cycle.
  - On the edge where counter==0: HI<=pending[63:32], LO<=pending[31:0], state<=IDLE, busy_out<=0, done_out<=1 for one cycle.
  - Result: busy_out is high for exactly LAT cycles after the accept edge. New HI/LO is visible in the first cycle busy_out=0.
- A new op can be accepted in the same cycle done_out=1, giving back-to-back throughput of LAT+1 cycles per op.
- Signed division: truncates toward zero; remainder takes the sign of the dividend.
- Overflow case 0x80000000 / 0xFFFFFFFF (signed): LO=0x80000000, HI=0.
- Divide by zero (div or divu): LO=0xFFFFFFFF, HI=rs_in. Latency is unchanged.
- Unsigned multiply: 32x32 zero-extended. Signed multiply: sign-extended.
- mf_req_in while IDLE: no stall; the reader samples hi_out/lo_out directly.
- Reset asserted mid-operation: the op is aborted and HI/LO return to 0.

Optional Feature:
MD_FLUSH_EN:
- When defined, adds input port flush_in (1 bit), which is the exception/eret flush from the pipeline.
- flush_in=1:
  - Aborts any busy op at the next edge (state<=IDLE, busy_out<=0, no commit, no done_out).
  - Suppresses acceptance of start_in that cycle, including MTHI/MTLO.
  - Forces stall_out=0.
- Undefined: the port does not exist, and an op once accepted always commits.

Decomposition:
- Shared package/header: MD_* op constants and the op width (3).
- The instruction-to-MD-op mapping lives with the decoder, not here.
- One natural sub-module: md_latency_counter (load value, load enable, decrement, zero flag), reused for both latencies.
- The arithmetic stays inline in md_sequencer.

Test Plan:
1. MULT with rs=0xFFFFFFFF, rt=2: busy_out high for 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE; done_out pulses once.
2. DIVU rs=7, rt=2, then mf_req_in on the next cycle: stall_out=1 for 10 cycles; then HI=1, LO=3 with stall released.
3. DIV rs=0x80000000, rt=0xFFFFFFFF -> LO=0x80000000, HI=0. DIV rs=5, rt=0 -> LO=0xFFFFFFFF, HI=5.
4. MTHI rs=0x1234 while IDLE: hi_out=0x1234 the next cycle, busy_out stays 0. The same MTHI during BUSY_MUL -> stall_out=1, and HI takes the mult result first, then 0x1234.
5. Drop rst_n 3 cycles into DIV: hi_out, lo_out and busy_out go to 0 immediately; after release no done_out appears. With MD_FLUSH_EN, flush_in mid-MULT leaves HI/LO at their prior values.

Source files
------------

// File: rtl/md_sequencer_pkg.sv
// Shared definitions for the multiply/divide sequencer: op codes, op width,
// FSM state encoding and counter width.
package md_sequencer_pkg;

    localparam int MD_OP_W  = 3;
    localparam int MD_CNT_W = 4;

    typedef logic [MD_OP_W-1:0] md_op_t;

    localparam md_op_t MD_NONE  = 3'd0;
    localparam md_op_t MD_MULT  = 3'd1;
    localparam md_op_t MD_MULTU = 3'd2;
    localparam md_op_t MD_DIV   = 3'd3;
    localparam md_op_t MD_DIVU  = 3'd4;
    localparam md_op_t MD_MTHI  = 3'd5;
    localparam md_op_t MD_MTLO  = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_BUSY_MUL = 2'd1,
        ST_BUSY_DIV = 2'd2
    } md_state_t;

    // Op code 7 is reserved and behaves exactly like MD_NONE.
    function automatic logic md_op_is_real(input md_op_t op);
        return (op != MD_NONE) && (op <= MD_MTLO);
    endfunction

endpackage

// File: rtl/md_latency_counter.sv
// Down-counter used to time mult/div occupancy. Loaded with LAT-1 on accept,
// decrements while enabled and holds at zero; zero is the terminal-count flag.
module md_latency_counter
    import md_sequencer_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load_en,
    input  logic [MD_CNT_W-1:0] load_val,
    input  logic                dec_en,
    output logic                zero
);

    logic [MD_CNT_W-1:0] count;

    // Load takes priority over decrement; the count never wraps below zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load_en) begin
            count <= load_val;
        end else if (dec_en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/md_sequencer.sv
// Multi-cycle multiply/divide controller owning the HI/LO registers.
// Optional build macro: MD_FLUSH_EN adds flush_in, which aborts an in-flight
// op, blocks acceptance and drops stall for the cycle it is asserted.
//
// state        | meaning
// -------------+------------------------------------------------------
// ST_IDLE      | free; accepts start_in, mthi/mtlo write HI/LO directly
// ST_BUSY_MUL  | product pending, counting down MULT_LAT cycles
// ST_BUSY_DIV  | quotient/remainder pending, counting down DIV_LAT cycles
module md_sequencer
    import md_sequencer_pkg::*;
#(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic               clk,
    input  logic               rst_n,
`ifdef MD_FLUSH_EN
    input  logic               flush_in,
`endif
    input  logic               start_in,
    input  logic [MD_OP_W-1:0] op_in,
    input  logic [31:0]        rs_in,
    input  logic [31:0]        rt_in,
    input  logic               mf_req_in,
    output logic               busy_out,
    output logic               stall_out,
    output logic               done_out,
    output logic [31:0]        hi_out,
    output logic [31:0]        lo_out
);

    localparam logic [MD_CNT_W-1:0] MULT_LOAD = MD_CNT_W'(MULT_LAT - 1);
    localparam logic [MD_CNT_W-1:0] DIV_LOAD  = MD_CNT_W'(DIV_LAT - 1);

    logic flush;
`ifdef MD_FLUSH_EN
    assign flush = flush_in;
`else
    assign flush = 1'b0;
`endif

    md_state_t           state, state_nxt;
    logic                accept;
    logic                op_mul, op_div;
    logic                cnt_load;
    logic [MD_CNT_W-1:0] cnt_load_val;
    logic                cnt_zero;
    logic                commit;
    logic [63:0]         pending;
    logic [63:0]         mul_res;
    logic [63:0]         div_res;
    logic [63:0]         mul_a, mul_b;
    logic signed [31:0]  sdiv_q, sdiv_r;

    assign op_mul = (op_in == MD_MULT) || (op_in == MD_MULTU);
    assign op_div = (op_in == MD_DIV)  || (op_in == MD_DIVU);
    assign accept = start_in && (state == ST_IDLE) && !flush;

    assign stall_out = busy_out && !flush &&
                       (mf_req_in || (start_in && md_op_is_real(op_in)));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, counter load and commit decode.
    always_comb begin
        state_nxt    = state;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        commit       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept && op_mul) begin
                    state_nxt    = ST_BUSY_MUL;
                    cnt_load     = 1'b1;
                    cnt_load_val = MULT_LOAD;
                end else if (accept && op_div) begin
                    state_nxt    = ST_BUSY_DIV;
                    cnt_load     = 1'b1;
                    cnt_load_val = DIV_LOAD;
                end
            end
            ST_BUSY_MUL, ST_BUSY_DIV: begin
                if (flush) begin
                    state_nxt = ST_IDLE;
                end else if (cnt_zero) begin
                    state_nxt = ST_IDLE;
                    commit    = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    md_latency_counter u_lat_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_en  (cnt_load),
        .load_val (cnt_load_val),
        .dec_en   (state != ST_IDLE),
        .zero     (cnt_zero)
    );

    // 64-bit product: operands are sign- or zero-extended, the low 64 bits
    // of the extended product are correct in both cases.
    always_comb begin
        if (op_in == MD_MULT) begin
            mul_a = {{32{rs_in[31]}}, rs_in};
            mul_b = {{32{rt_in[31]}}, rt_in};
        end else begin
            mul_a = {32'd0, rs_in};
            mul_b = {32'd0, rt_in};
        end
        mul_res = mul_a * mul_b;
    end

    assign sdiv_q = $signed(rs_in) / $signed(rt_in);
    assign sdiv_r = $signed(rs_in) % $signed(rt_in);

    // Division result as {remainder, quotient}, with the zero-divisor and
    // signed-overflow cases pinned to fixed architectural values.
    always_comb begin
        div_res = '0;
        if (rt_in == 32'd0) begin
            div_res = {rs_in, 32'hFFFF_FFFF};
        end else if (op_in == MD_DIV) begin
            if ((rs_in == 32'h8000_0000) && (rt_in == 32'hFFFF_FFFF)) begin
                div_res = {32'd0, 32'h8000_0000};
            end else begin
                div_res = {sdiv_r, sdiv_q};
            end
        end else begin
            div_res = {rs_in % rt_in, rs_in / rt_in};
        end
    end

    // Pending result capture, HI/LO writes and status flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending  <= '0;
            hi_out   <= '0;
            lo_out   <= '0;
            busy_out <= 1'b0;
            done_out <= 1'b0;
        end else begin
            busy_out <= (state_nxt != ST_IDLE);
            done_out <= commit;
            if (accept && op_mul) begin
                pending <= mul_res;
            end else if (accept && op_div) begin
                pending <= div_res;
            end
            if (commit) begin
                hi_out <= pending[63:32];
                lo_out <= pending[31:0];
            end else if (accept && (op_in == MD_MTHI)) begin
                hi_out <= rs_in;
            end else if (accept && (op_in == MD_MTLO)) begin
                lo_out <= rs_in;
            end
        end
    end

endmodule

// File: tb/tb_md_sequencer.sv
// Scoreboard bench for md_sequencer: the driver pushes expected HI/LO and
// busy length per mult/div, a monitor pops and compares on every done_out.
module tb_md_sequencer;
    import md_sequencer_pkg::*;

    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_in;
    logic [2:0]  op_in;
    logic [31:0] rs_in, rt_in;
    logic        mf_req_in;
    logic        busy_out, stall_out, done_out;
    logic [31:0] hi_out, lo_out;
`ifdef MD_FLUSH_EN
    logic        flush_in = 1'b0;
`endif

    md_sequencer #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef MD_FLUSH_EN
        .flush_in  (flush_in),
`endif
        .start_in  (start_in),
        .op_in     (op_in),
        .rs_in     (rs_in),
        .rt_in     (rt_in),
        .mf_req_in (mf_req_in),
        .busy_out  (busy_out),
        .stall_out (stall_out),
        .done_out  (done_out),
        .hi_out    (hi_out),
        .lo_out    (lo_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } exp_t;

    exp_t        exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Reference: plain integer arithmetic on 64-bit values; returns {hi, lo}.
    function automatic logic [63:0] ref_result(input logic [2:0] op,
                                               input logic [31:0] a,
                                               input logic [31:0] b);
        longint          sa, sb, q, r;
        longint unsigned ua, ub, p;
        logic [63:0]     res;
        ua  = a;
        ub  = b;
        sa  = $signed(a);
        sb  = $signed(b);
        res = '0;
        case (op)
            MD_MULT: begin
                q   = sa * sb;
                res = q;
            end
            MD_MULTU: begin
                p   = ua * ub;
                res = p;
            end
            MD_DIV, MD_DIVU: begin
                if (b == 32'd0) begin
                    res = {a, 32'hFFFF_FFFF};
                end else if (op == MD_DIVU) begin
                    q   = longint'(ua / ub);
                    r   = longint'(ua % ub);
                    res = {r[31:0], q[31:0]};
                end else begin
                    q = (sa < 0 ? -sa : sa) / (sb < 0 ? -sb : sb);
                    r = (sa < 0 ? -sa : sa) % (sb < 0 ? -sb : sb);
                    if ((sa < 0) != (sb < 0)) q = -q;
                    if (sa < 0) r = -r;
                    res = {r[31:0], q[31:0]};
                end
            end
            default: res = '0;
        endcase
        return res;
    endfunction

    // Called at a negedge; waits for the unit to be free, presents the op for
    // one cycle and returns at the negedge after the accepting edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int          guard;
        exp_t        e;
        logic [63:0] r;
        guard = 0;
        while (busy_out && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 40) chk("issue_wait_idle", 64'(busy_out), 64'd0);
        start_in = 1'b1;
        op_in    = op;
        rs_in    = a;
        rt_in    = b;
        if (op == MD_MULT || op == MD_MULTU || op == MD_DIV || op == MD_DIVU) begin
            r     = ref_result(op, a, b);
            e.hi  = r[63:32];
            e.lo  = r[31:0];
            e.lat = (op == MD_MULT || op == MD_MULTU) ? MULT_LAT : DIV_LAT;
            exp_q.push_back(e);
            model_hi = e.hi;
            model_lo = e.lo;
        end else if (op == MD_MTHI) begin
            model_hi = a;
        end else if (op == MD_MTLO) begin
            model_lo = a;
        end
        @(negedge clk);
        start_in = 1'b0;
        op_in    = MD_NONE;
        if (op == MD_MTHI || op == MD_MTLO) begin
            chk("mt_hi", 64'(hi_out), 64'(model_hi));
            chk("mt_lo", 64'(lo_out), 64'(model_lo));
            chk("mt_busy", 64'(busy_out), 64'd0);
        end
    endtask

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(1, 9));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: on each done pulse, compare HI/LO and the busy run length.
    initial begin : monitor
        int   run;
        exp_t e;
        run = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                run = 0;
            end else begin
                if (done_out) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_done: got done_out=1, expected no op in flight");
                    end else begin
                        e = exp_q.pop_front();
                        chk("done_hi", 64'(hi_out), 64'(e.hi));
                        chk("done_lo", 64'(lo_out), 64'(e.lo));
                        chk("busy_cycles", 64'(run), 64'(e.lat));
                    end
                    run = 0;
                end
                if (busy_out) run++;
            end
        end
    end

    initial begin : driver
        int n;
        logic [31:0] save_hi, save_lo;
        rst_n     = 1'b0;
        start_in  = 1'b0;
        op_in     = MD_NONE;
        rs_in     = '0;
        rt_in     = '0;
        mf_req_in = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_hi", 64'(hi_out), 64'd0);
        chk("rst_lo", 64'(lo_out), 64'd0);
        chk("rst_busy_done", {62'd0, busy_out, done_out}, 64'd0);
        chk("rst_stall", 64'(stall_out), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_mf_no_stall", 64'(stall_out), 64'd0);
        mf_req_in = 1'b0;

        // Signed multiply of -1 by 2.
        issue(MD_MULT, 32'hFFFF_FFFF, 32'd2);

        // DIVU followed by an mfhi/mflo read that must stall for DIV_LAT cycles.
        issue(MD_DIVU, 32'd7, 32'd2);
        mf_req_in = 1'b1;
        #1;
        n = 0;
        while (stall_out && n < 30) begin
            n++;
            @(negedge clk);
        end
        chk("mf_stall_cycles", 64'(n), 64'(DIV_LAT));
        chk("mf_read_hi", 64'(hi_out), 64'd1);
        chk("mf_read_lo", 64'(lo_out), 64'd3);
        mf_req_in = 1'b0;

        // Signed overflow and divide by zero.
        issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(MD_DIV, 32'd5, 32'd0);

        // MTHI while idle, then MTHI held against a busy multiply.
        issue(MD_MTHI, 32'h1234, 32'd0);
        issue(MD_MULT, 32'd3, 32'd4);
        start_in = 1'b1;
        op_in    = MD_MTHI;
        rs_in    = 32'h1234;
        #1;
        chk("mthi_busy_stall", 64'(stall_out), 64'd1);
        n = 0;
        while (busy_out && n < 30) begin
            n++;
            @(negedge clk);
        end
        chk("mthi_after_mul_hi", 64'(hi_out), 64'd0);
        @(negedge clk);
        start_in = 1'b0;
        op_in    = MD_NONE;
        model_hi = 32'h1234;
        chk("mthi_held_hi", 64'(hi_out), 64'h1234);
        chk("mthi_held_lo", 64'(lo_out), 64'd12);

        // Reset in the middle of a divide.
        issue(MD_DIV, 32'd100, 32'd7);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_hi", 64'(hi_out), 64'd0);
        chk("midrst_lo", 64'(lo_out), 64'd0);
        chk("midrst_busy", 64'(busy_out), 64'd0);
        exp_q.delete();
        model_hi = '0;
        model_lo = '0;
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        repeat (15) begin
            @(negedge clk);
            if (done_out) n++;
        end
        chk("midrst_no_done", 64'(n), 64'd0);

`ifdef MD_FLUSH_EN
        // Flush mid-multiply leaves HI/LO untouched.
        issue(MD_MTLO, 32'hABCD, 32'd0);
        save_hi = model_hi;
        save_lo = model_lo;
        issue(MD_MULT, 32'd7, 32'd9);
        void'(exp_q.pop_back());
        model_hi = save_hi;
        model_lo = save_lo;
        @(negedge clk);
        flush_in = 1'b1;
        @(negedge clk);
        flush_in = 1'b0;
        chk("flush_busy", 64'(busy_out), 64'd0);
        repeat (MULT_LAT + 2) @(negedge clk);
        chk("flush_hi", 64'(hi_out), 64'(save_hi));
        chk("flush_lo", 64'(lo_out), 64'(save_lo));
`else
        save_hi = model_hi;
        save_lo = model_lo;
        chk("post_reset_hi", 64'(hi_out), 64'(save_hi));
        chk("post_reset_lo", 64'(lo_out), 64'(save_lo));
`endif

        // Randomized mix, including back-to-back issue on the done cycle.
        for (int i = 0; i < 40; i++) begin
            issue(3'($urandom_range(1, 6)), rand_word(), rand_word());
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("drain_queue", 64'(exp_q.size()), 64'd0);
        chk("final_hi", 64'(hi_out), 64'(model_hi));
        chk("final_lo", 64'(lo_out), 64'(model_lo));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
